vr_log_hdr_ring: RTL

- Parametrised circular store for VR log-entry headers (log_entry_hdr), one entry per op number.
- Owns hdr_log_head/hdr_log_tail, first_log_op, last_op and last_commit for the replica state; the data log is managed separately.
- Supports in-order append, lookup by op number, head cleanup (clean_up_to), tail truncation for view change, and commit marking.
- Successor to the fixed-depth header log: depth is generic, truncation and state override on read are new.

---
 rtl/vr_log_hdr_ring_pkg.sv | 40 ++++
 rtl/vr_log_hdr_ram.sv | 28 ++
 rtl/vr_log_hdr_ring.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vr_log_hdr_ring_pkg.sv
// Shared types for the VR log-entry header ring: header layout, entry states and status/response
// bundles.
package vr_log_hdr_ring_pkg;

    localparam int unsigned INT_W      = 64;
    localparam int unsigned HDR_LEN_W  = 30;

    typedef enum logic [1:0] {
        LOG_STATE_EMPTY    = 2'd0,
        LOG_STATE_PREPARED = 2'd1,
        LOG_STATE_COMMITED = 2'd2
    } log_entry_state_e;

    typedef struct packed {
        logic [INT_W-1:0]     hdr_view;
        logic [INT_W-1:0]     hdr_op_num;
        log_entry_state_e     hdr_state;
        logic [HDR_LEN_W-1:0] hdr_data_len;
    } log_entry_hdr;

    localparam int unsigned LOG_ENTRY_HDR_W = $bits(log_entry_hdr);
    // Bit offset of hdr_op_num inside a flattened header.
    localparam int unsigned HDR_OP_LSB      = $bits(log_entry_state_e) + HDR_LEN_W;

    localparam int unsigned STATUS_PTR_W = 32;

    typedef struct packed {
        logic [STATUS_PTR_W-1:0] head;
        logic [STATUS_PTR_W-1:0] tail;
        logic [INT_W-1:0]        first_log_op;
        logic [INT_W-1:0]        last_op;
        logic [INT_W-1:0]        last_commit;
    } vr_log_hdr_status;

    typedef struct packed {
        logic         hit;
        log_entry_hdr hdr;
    } vr_log_hdr_rd_resp;

endpackage

// File: rtl/vr_log_hdr_ram.sv
// Header storage: one write port, one registered read port; a read of the slot being written
// returns the previous contents.
module vr_log_hdr_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 160,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/vr_log_hdr_ring.sv
// Circular store of VR log-entry headers indexed by op number, with cleanup, truncation and
// commit tracking. Define VR_LOG_HDR_FWD_EN to forward a same-cycle append to a lookup.
module vr_log_hdr_ring
    import vr_log_hdr_ring_pkg::*;
#(
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned OP_W     = INT_W,
    localparam int unsigned DEPTH_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       append_val,
    input  logic [LOG_ENTRY_HDR_W-1:0] append_hdr,
    output logic                       append_rdy,
    output logic                       append_err,
    input  logic                       rd_req_val,
    input  logic [OP_W-1:0]            rd_req_opnum,
    output logic                       rd_req_rdy,
    output logic                       rd_resp_val,
    output logic                       rd_resp_hit,
    output logic [LOG_ENTRY_HDR_W-1:0] rd_resp_hdr,
    input  logic                       rd_resp_rdy,
    input  logic                       clean_val,
    input  logic [OP_W-1:0]            clean_up_to,
    input  logic                       commit_val,
    input  logic [OP_W-1:0]            commit_opnum,
    input  logic                       trunc_val,
    input  logic [OP_W-1:0]            trunc_last_op,
    output logic [DEPTH_W:0]           hdr_log_head,
    output logic [DEPTH_W:0]           hdr_log_tail,
    output logic [OP_W-1:0]            first_log_op,
    output logic [OP_W-1:0]            last_op,
    output logic [OP_W-1:0]            last_commit,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PTR_W = DEPTH_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OP_W-1:0]  first_q, first_d, last_q, last_d, commit_q, commit_d;
    logic             err_q, err_d;
    logic             resp_val_q, resp_val_d, resp_hit_q, resp_hit_d, resp_cmt_q, resp_cmt_d;

    logic [PTR_W-1:0]   count;
    logic [OP_W-1:0]    app_op;
    logic               app_acc, app_seq;
    logic               rd_acc, rd_in_range, rd_fwd;
    logic [DEPTH_W-1:0] rd_idx;
    logic [LOG_ENTRY_HDR_W-1:0] ram_rdata;
    log_entry_hdr       resp_hdr;

    logic [PTR_W-1:0] t_tail, t_count, free;
    logic [OP_W-1:0]  t_last, free_op, commit_cand, commit_tmp;

    assign count      = tail_q - head_q;
    assign empty      = (count == '0);
    assign full       = (count == PTR_W'(DEPTH));
    assign app_op     = append_hdr[HDR_OP_LSB +: OP_W];
    assign append_rdy = ~full & ~trunc_val;
    assign app_acc    = append_val & append_rdy;
    assign app_seq    = app_acc & (empty | (app_op == last_q + 1'b1));

    assign rd_req_rdy  = ~resp_val_q | rd_resp_rdy;
    assign rd_acc      = rd_req_val & rd_req_rdy;
    assign rd_in_range = ~empty & (rd_req_opnum >= first_q) & (rd_req_opnum <= last_q);
    assign rd_idx      = head_q[DEPTH_W-1:0] + DEPTH_W'(rd_req_opnum - first_q);

`ifdef VR_LOG_HDR_FWD_EN
    logic         resp_fwd_q;
    log_entry_hdr resp_fwd_hdr_q;
    assign rd_fwd = app_seq & (rd_req_opnum == app_op);
`else
    assign rd_fwd = 1'b0;
`endif

    // Truncation first, then cleanup on the truncated ring, then append, then commit.
    always_comb begin
        t_tail     = tail_q;
        t_last     = last_q;
        commit_tmp = commit_q;
        if (trunc_val) begin
            if (trunc_last_op < first_q) begin
                t_tail = head_q;
                t_last = first_q - 1'b1;
            end else if (trunc_last_op < last_q) begin
                t_tail = head_q + PTR_W'(trunc_last_op - first_q + 1'b1);
                t_last = trunc_last_op;
            end
            if (commit_q > t_last) begin
                commit_tmp = t_last;
            end
        end

        t_count = t_tail - head_q;
        free_op = '0;
        free    = '0;
        if (clean_val && (clean_up_to > first_q)) begin
            free_op = clean_up_to - first_q;
            free    = (free_op < OP_W'(t_count)) ? PTR_W'(free_op) : t_count;
        end
        head_d  = head_q + free;
        first_d = first_q + OP_W'(free);

        tail_d = t_tail;
        last_d = t_last;
        err_d  = 1'b0;
        if (app_acc) begin
            if (app_seq) begin
                tail_d = tail_q + 1'b1;
                last_d = app_op;
                if (empty) begin
                    first_d = app_op;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        commit_cand = (commit_opnum < t_last) ? commit_opnum : t_last;
        if (commit_val && (commit_cand > commit_tmp)) begin
            commit_tmp = commit_cand;
        end
        commit_d = commit_tmp;
    end

    always_comb begin
        resp_val_d = resp_val_q;
        resp_hit_d = resp_hit_q;
        resp_cmt_d = resp_cmt_q;
        if (rd_acc) begin
            resp_val_d = 1'b1;
            resp_hit_d = rd_in_range | rd_fwd;
            resp_cmt_d = (rd_req_opnum <= commit_q);
        end else if (rd_resp_rdy) begin
            resp_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            first_q    <= '0;
            last_q     <= '0;
            commit_q   <= '0;
            err_q      <= 1'b0;
            resp_val_q <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_cmt_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            first_q    <= first_d;
            last_q     <= last_d;
            commit_q   <= commit_d;
            err_q      <= err_d;
            resp_val_q <= resp_val_d;
            resp_hit_q <= resp_hit_d;
            resp_cmt_q <= resp_cmt_d;
        end
    end

`ifdef VR_LOG_HDR_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_fwd_q     <= 1'b0;
            resp_fwd_hdr_q <= '0;
        end else if (rd_acc) begin
            resp_fwd_q     <= rd_fwd;
            resp_fwd_hdr_q <= log_entry_hdr'(append_hdr);
        end
    end
`endif

    vr_log_hdr_ram #(
        .DEPTH (DEPTH),
        .WIDTH (LOG_ENTRY_HDR_W)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (app_seq),
        .wr_addr_i (tail_q[DEPTH_W-1:0]),
        .wr_data_i (append_hdr),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_idx),
        .rd_data_o (ram_rdata)
    );

    // Stored state field is ignored; it is recomputed from the commit point at lookup time.
    always_comb begin
        resp_hdr = log_entry_hdr'(ram_rdata);
`ifdef VR_LOG_HDR_FWD_EN
        if (resp_fwd_q) begin
            resp_hdr = resp_fwd_hdr_q;
        end
`endif
        resp_hdr.hdr_state = resp_cmt_q ? LOG_STATE_COMMITED : LOG_STATE_PREPARED;
        if (!resp_hit_q) begin
            resp_hdr = '0;
        end
    end

    assign rd_resp_val  = resp_val_q;
    assign rd_resp_hit  = resp_hit_q;
    assign rd_resp_hdr  = resp_hdr;
    assign append_err   = err_q;
    assign hdr_log_head = head_q;
    assign hdr_log_tail = tail_q;
    assign first_log_op = first_q;
    assign last_op      = last_q;
    assign last_commit  = commit_q;

endmodule
